// File: rtl/spi2serial.sv
// spi2serial: SPI-slave (mode 0) to UART bridge.
// Bytes clocked in on i_mosi are queued in a small FIFO and sent as 8N1 UART
// frames on o_tx when i_cts allows. UART bytes received on i_rx are held in a
// one-byte register and returned on o_miso in the next SPI byte slot.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//   FIFO_DEPTH    SPI->UART FIFO entries (power of 2, >= 2)
// Ports:
//   i_clk, i_reset        system clock, synchronous active-high reset
//   i_cs_n, i_sck, i_mosi SPI slave inputs (asynchronous, oversampled)
//   o_miso                SPI data out, MSB first, 1 when deselected
//   o_tx, i_rx            UART transmit / receive (idle high)
//   o_rts                 high when a UART byte on i_rx can be accepted
//   i_cts                 high when the peer accepts a UART byte on o_tx
//   o_overflow            sticky: a SPI byte was dropped on a full FIFO
// Configuration:
//   SPI2SERIAL_RX_EN      defined: UART RX path and holding register present;
//                         undefined: i_rx ignored, o_rts = 0, o_miso sends 0xFF.
module spi2serial #(
    parameter int unsigned CLKS_PER_BIT = 35,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_cs_n,
    input  logic i_sck,
    input  logic i_mosi,
    output logic o_miso,
    output logic o_tx,
    input  logic i_rx,
    output logic o_rts,
    input  logic i_cts,
    output logic o_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    // ---------------- synchronisers ([1] = synced, [2] = previous) -------------
    logic [2:0] r_cs_sync, r_sck_sync;
    logic [1:0] r_mosi_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cs_sync   <= 3'b111;
            r_sck_sync  <= 3'b000;
            r_mosi_sync <= 2'b00;
        end else begin
            r_cs_sync   <= {r_cs_sync[1:0], i_cs_n};
            r_sck_sync  <= {r_sck_sync[1:0], i_sck};
            r_mosi_sync <= {r_mosi_sync[0], i_mosi};
        end
    end

    logic w_cs_low, w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;
    assign w_cs_low   = ~r_cs_sync[1];
    assign w_cs_fall  = r_cs_sync[2] & ~r_cs_sync[1];
    assign w_cs_rise  = ~r_cs_sync[2] & r_cs_sync[1];
    assign w_sck_rise = ~r_sck_sync[2] & r_sck_sync[1] & w_cs_low;
    assign w_sck_fall = r_sck_sync[2] & ~r_sck_sync[1] & w_cs_low;

    // ---------------- SPI slave ----------------
    logic [2:0] r_bitcnt;
    logic       r_got_bit;
    logic [7:0] r_rx_shift, r_miso_shift;
    logic       w_hold_valid, w_hold_take, w_push_req;
    logic [7:0] w_hold_byte, w_reload_byte, w_push_data;

    assign w_reload_byte = w_hold_valid ? w_hold_byte : 8'hFF;
    assign w_hold_take   = w_cs_fall | (w_sck_fall & (r_bitcnt == 3'd0) & r_got_bit);
    assign w_push_req    = w_sck_rise & ~w_cs_fall & (r_bitcnt == 3'd7);
    assign w_push_data   = {r_rx_shift[6:0], r_mosi_sync[1]};
    assign o_miso        = r_miso_shift[7];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bitcnt     <= 3'd0;
            r_got_bit    <= 1'b0;
            r_rx_shift   <= 8'h00;
            r_miso_shift <= 8'hFF;
        end else if (w_cs_fall) begin
            r_bitcnt     <= 3'd0;
            r_got_bit    <= 1'b0;
            r_miso_shift <= w_reload_byte;
        end else if (w_cs_rise) begin
            // partial byte is discarded; shifter of all ones keeps miso high
            r_bitcnt     <= 3'd0;
            r_got_bit    <= 1'b0;
            r_miso_shift <= 8'hFF;
        end else if (w_sck_rise) begin
            r_rx_shift <= w_push_data;
            r_bitcnt   <= r_bitcnt + 3'd1;
            r_got_bit  <= 1'b1;
        end else if (w_sck_fall) begin
            if ((r_bitcnt == 3'd0) && r_got_bit) begin
                r_miso_shift <= w_reload_byte;
            end else begin
                r_miso_shift <= {r_miso_shift[6:0], 1'b1};
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]  r_fifo [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        r_overflow, w_full, w_empty;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_overflow = r_overflow;

    always_ff @(posedge i_clk) begin
        if (w_push_req && !w_full) begin
            r_fifo[r_wr_ptr[AW-1:0]] <= w_push_data;
        end
    end

    // full is taken from registered pointers, so a push that meets a pop on a
    // full FIFO is still dropped
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (w_push_req) begin
            if (w_full) r_overflow <= 1'b1;
            else        r_wr_ptr   <= r_wr_ptr + PTR_ONE;
        end
    end

    // ---------------- UART TX ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    tx_state_t     r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_byte;
    logic          r_tx;

    assign o_tx = r_tx;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_byte  <= 8'h00;
            r_tx       <= 1'b1;
            r_rd_ptr   <= '0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (!w_empty && i_cts) begin
                        r_tx_byte  <= r_fifo[r_rd_ptr[AW-1:0]];
                        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                        r_tx       <= 1'b0;
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == LAST_CNT) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= 3'd0;
                        r_tx       <= r_tx_byte[0];
                        r_tx_byte  <= {1'b0, r_tx_byte[7:1]};
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == LAST_CNT) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_bit  <= r_tx_bit + 3'd1;
                            r_tx      <= r_tx_byte[0];
                            r_tx_byte <= {1'b0, r_tx_byte[7:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
                default: begin // TX_STOP
                    if (r_tx_cnt == LAST_CNT) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // ---------------- UART RX and holding register ----------------
`ifdef SPI2SERIAL_RX_EN
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t     r_rx_state;
    logic [2:0]    r_rx_sync;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_data, r_hold_byte;
    logic          r_hold_valid;

    assign w_hold_valid = r_hold_valid;
    assign w_hold_byte  = r_hold_byte;
    assign o_rts        = ~(r_hold_valid | i_reset);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_sync    <= 3'b111;
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= 3'd0;
            r_rx_data    <= 8'h00;
            r_hold_byte  <= 8'h00;
            r_hold_valid <= 1'b0;
        end else begin
            r_rx_sync <= {r_rx_sync[1:0], i_rx};
            if (w_hold_take) r_hold_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_sync[2] && !r_rx_sync[1]) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_CNT) begin
                        // line back high at mid start bit: treat as a glitch
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= 3'd0;
                        r_rx_state <= r_rx_sync[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == LAST_CNT) begin
                        r_rx_cnt  <= '0;
                        r_rx_data <= {r_rx_sync[1], r_rx_data[7:1]};
                        r_rx_bit  <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
                default: begin // RX_STOP
                    if (r_rx_cnt == LAST_CNT) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        if (r_rx_sync[1] && !r_hold_valid) begin
                            r_hold_byte  <= r_rx_data;
                            r_hold_valid <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end
`else
    logic w_unused;
    assign w_unused     = i_rx ^ w_hold_take;
    assign w_hold_valid = 1'b0;
    assign w_hold_byte  = 8'hFF;
    assign o_rts        = 1'b0;
`endif

endmodule

// File: tb/tb_spi2serial.sv
// Bench for spi2serial: table of single SPI bytes with expected UART/MISO
// results, plus hand sequences for FIFO overflow, cts gating, UART RX and reset.
module tb_spi2serial;

    localparam int CPB = 35;

    logic clk, reset, cs_n, sck, mosi, miso, tx, rx, rts, cts, overflow;

    spi2serial #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_cs_n    (cs_n),
        .i_sck     (sck),
        .i_mosi    (mosi),
        .o_miso    (miso),
        .o_tx      (tx),
        .i_rx      (rx),
        .o_rts     (rts),
        .i_cts     (cts),
        .o_overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // decoded UART frames from tx
    logic [7:0] byte_q[$];
    int         ok_q[$];
    int         fall_q[$];
    int         last_fall = -1;
    int         first_rise = -1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // UART monitor: samples each bit in its middle
    initial begin
        logic [7:0] b;
        int f, ok;
        forever begin
            tick();
            if (tx === 1'b0 && reset === 1'b0) begin
                f = cyc;
                last_fall = f;
                first_rise = -1;
                repeat (CPB / 2) tick();
                ok = (tx === 1'b0) ? 1 : 0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) tick();
                    b[i] = tx;
                end
                repeat (CPB) tick();
                if (tx !== 1'b1) ok = 0;
                byte_q.push_back(b);
                ok_q.push_back(ok);
                fall_q.push_back(f);
            end
        end
    end

    // first rising edge of tx after each detected start bit
    initial begin
        logic prev;
        prev = 1'b1;
        forever begin
            tick();
            if (prev === 1'b0 && tx === 1'b1 && first_rise < 0) first_rise = cyc;
            prev = tx;
        end
    end

    task automatic clear_q();
        byte_q.delete();
        ok_q.delete();
        fall_q.delete();
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (5) tick();
    endtask

    task automatic cs_high();
        repeat (5) tick();
        cs_n = 1'b1;
        repeat (5) tick();
    endtask

    task automatic spi_byte(input logic [7:0] d, output logic [7:0] m);
        for (int i = 7; i >= 0; i--) begin
            mosi = d[i];
            repeat (5) tick();
            m[i] = miso;
            sck = 1'b1;
            repeat (5) tick();
            sck = 1'b0;
        end
    endtask

    task automatic wait_bytes(input string name, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (byte_q.size() >= n) break;
            tick();
        end
        cmp(name, byte_q.size(), n);
    endtask

    task automatic uart_send(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) tick();
        end
        rx = stop;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (CPB) tick();
    endtask

    typedef struct {
        logic [7:0] spi_in;
        logic [7:0] uart_out;
        logic [7:0] miso_out;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] m;
        int lows;

        vecs[0] = '{spi_in: 8'h00, uart_out: 8'h00, miso_out: 8'hFF};
        vecs[1] = '{spi_in: 8'hFF, uart_out: 8'hFF, miso_out: 8'hFF};
        vecs[2] = '{spi_in: 8'h81, uart_out: 8'h81, miso_out: 8'hFF};
        vecs[3] = '{spi_in: 8'h6E, uart_out: 8'h6E, miso_out: 8'hFF};
        vecs[4] = '{spi_in: 8'h12, uart_out: 8'h12, miso_out: 8'hFF};

        reset = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; rx = 1'b1; cts = 1'b1;
        repeat (3) tick();
        cmp("reset_tx", tx, 1);
        cmp("reset_miso", miso, 1);
        cmp("reset_rts", rts, 0);
        cmp("reset_overflow", overflow, 0);
        reset = 1'b0;
        tick();
`ifdef SPI2SERIAL_RX_EN
        cmp("rts_after_reset", rts, 1);
`else
        cmp("rts_after_reset", rts, 0);
`endif

        // 0xA5 frame: decoded bits and start-bit length
        clear_q();
        cs_low();
        spi_byte(8'hA5, m);
        cs_high();
        wait_bytes("a5_count", 1, 1000);
        if (byte_q.size() >= 1) begin
            cmp("a5_data", byte_q[0], 8'hA5);
            cmp("a5_frame", ok_q[0], 1);
            cmp("a5_start_len", first_rise - fall_q[0], CPB);
        end
        cmp("a5_miso", m, 8'hFF);
        repeat (50) tick();

        // table-driven single bytes
        for (int v = 0; v < 5; v++) begin
            clear_q();
            cs_low();
            spi_byte(vecs[v].spi_in, m);
            cs_high();
            cmp($sformatf("vec%0d_miso", v), m, vecs[v].miso_out);
            wait_bytes($sformatf("vec%0d_count", v), 1, 1000);
            if (byte_q.size() >= 1) begin
                cmp($sformatf("vec%0d_data", v), byte_q[0], vecs[v].uart_out);
                cmp($sformatf("vec%0d_frame", v), ok_q[0], 1);
            end
            repeat (50) tick();
        end

        // five bytes into a 4-deep FIFO with cts low
        clear_q();
        cts = 1'b0;
        cs_low();
        for (int i = 1; i <= 5; i++) spi_byte(8'(i), m);
        cs_high();
        cmp("ovf_set", overflow, 1);
        repeat (100) tick();
        cmp("ovf_held_by_cts", byte_q.size(), 0);
        cts = 1'b1;
        wait_bytes("ovf_count", 4, 2500);
        repeat (600) tick();
        cmp("ovf_no_fifth", byte_q.size(), 4);
        for (int i = 0; i < 4 && i < byte_q.size(); i++) begin
            cmp($sformatf("ovf_data%0d", i), byte_q[i], i + 1);
        end
        if (fall_q.size() >= 2) cmp("b2b_spacing", fall_q[1] - fall_q[0], 10 * CPB + 1);

        // cts dropped mid-frame
        clear_q();
        cts = 1'b0;
        cs_low();
        spi_byte(8'h3C, m);
        spi_byte(8'h7E, m);
        cs_high();
        cts = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (tx == 1'b0) break;
            tick();
        end
        cmp("cts_frame_start", tx, 0);
        repeat (50) tick();
        cts = 1'b0;
        wait_bytes("cts_first", 1, 1000);
        repeat (700) tick();
        cmp("cts_hold", byte_q.size(), 1);
        if (byte_q.size() >= 1) begin
            cmp("cts_data0", byte_q[0], 8'h3C);
            cmp("cts_frame0", ok_q[0], 1);
        end
        cts = 1'b1;
        wait_bytes("cts_second", 2, 1000);
        if (byte_q.size() >= 2) cmp("cts_data1", byte_q[1], 8'h7E);
        repeat (50) tick();

        // UART -> SPI path
`ifdef SPI2SERIAL_RX_EN
        uart_send(8'h5A, 1'b1);
        repeat (3) tick();
        cmp("rx_rts_low", rts, 0);
        cs_low();
        cmp("rx_rts_freed", rts, 1);
        spi_byte(8'h00, m);
        cmp("rx_miso_5a", m, 8'h5A);
        spi_byte(8'h00, m);
        cmp("rx_miso_ff", m, 8'hFF);
        cs_high();
        uart_send(8'h99, 1'b0);
        repeat (5) tick();
        cmp("rx_badstop_rts", rts, 1);
        rx = 1'b0;
        repeat (10) tick();
        rx = 1'b1;
        repeat (60) tick();
        cmp("rx_glitch_rts", rts, 1);
        uart_send(8'h33, 1'b1);
        repeat (3) tick();
        cmp("rx_after_glitch_rts", rts, 0);
        cs_low();
        spi_byte(8'h00, m);
        cs_high();
        cmp("rx_miso_33", m, 8'h33);
`else
        uart_send(8'h5A, 1'b1);
        repeat (3) tick();
        cmp("norx_rts", rts, 0);
        cs_low();
        spi_byte(8'h00, m);
        cs_high();
        cmp("norx_miso", m, 8'hFF);
`endif
        repeat (1500) tick();

        // reset in the middle of 0xC3 with 0x11 still queued
        clear_q();
        last_fall = -1;
        cs_low();
        spi_byte(8'hC3, m);
        spi_byte(8'h11, m);
        cs_high();
        for (int i = 0; i < 500; i++) begin
            if (last_fall >= 0 && cyc >= last_fall + 150) break;
            tick();
        end
        cmp("rst_mid_bit3", tx, 0);
        reset = 1'b1;
        tick();
        cmp("rst_tx_high", tx, 1);
        cmp("rst_overflow", overflow, 0);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        cmp("rst_fifo_empty", lows, 0);
        clear_q();
        cs_low();
        spi_byte(8'h42, m);
        cs_high();
        wait_bytes("rst_resume_count", 1, 1000);
        if (byte_q.size() >= 1) cmp("rst_resume_data", byte_q[0], 8'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
